// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store sequencer between the MEM stage and the data bus.
//
// Accepts one memory instruction at a time, checks its alignment, issues a
// single word-aligned bus transaction with byte enables and replicated store
// data, waits for a variable-latency ack (bounded by TIMEOUT), and returns
// extended load data with a one-cycle completion pulse.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_we/req_op/req_addr/req_wdata : request from the MEM stage
//   flush                                      : pipeline flush
//   stall                                      : hold the pipeline (combinational)
//   resp_valid/rdata/exc_code                  : completion (registered)
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   : bus request (registered)
//   bus_ack/bus_rdata                          : bus response
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [1:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  localparam logic [1:0]  EXC_NONE = 2'b00;
  localparam logic [1:0]  EXC_ADEL = 2'b01;
  localparam logic [1:0]  EXC_ADES = 2'b10;
  localparam logic [1:0]  EXC_TMO  = 2'b11;
  // Last counter value before the timeout fires; the counter starts at 0
  // in the first WAIT cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  a_reg;
  logic [2:0]  op_reg;

  // Request decode (IDLE side)
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    is_byte    = (req_op == 3'd1) || (req_op == 3'd2);
    is_half    = (req_op == 3'd3) || (req_op == 3'd4);
    aligned    = 1'b1;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    if (is_half) begin
      aligned = ~req_addr[0];
    end else if (!is_byte) begin
      aligned = (req_addr[1:0] == 2'b00);
    end
    if (req_we) begin
      if (is_byte) begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end else if (is_half) begin
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
    end
  end

  // Load extension (WAIT side), driven by the address/op captured at accept
  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = bus_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte = lane[a_reg];
    sel_half = a_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_reg)
      3'd1:    load_ext = {24'b0, sel_byte};
      3'd2:    load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'd3:    load_ext = {16'b0, sel_half};
      3'd4:    load_ext = {{16{sel_half[15]}}, sel_half};
      default: load_ext = bus_rdata;
    endcase
  end

  // The pipeline is released in the cycle the response pulses; a flush
  // releases it immediately except while an abandoned access drains.
  assign stall = (req_valid & ~resp_valid & ~flush) | (state_reg == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      op_reg     <= '0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      exc_code   <= EXC_NONE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && !flush) begin
            if (!aligned) begin
              state_reg  <= DONE;
              resp_valid <= 1'b1;
              exc_code   <= req_we ? EXC_ADES : EXC_ADEL;
              rdata      <= '0;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= '0;
              a_reg     <= req_addr[1:0];
              op_reg    <= req_op;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= be_next;
              bus_wdata <= wdata_next;
            end
          end
        end

        WAIT: begin
          if (bus_ack) begin
            // An ack always completes the access; a simultaneous flush only
            // hides the response from the pipeline.
            state_reg  <= DONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            resp_valid <= ~flush;
            exc_code   <= EXC_NONE;
            rdata      <= bus_we ? 32'b0 : load_ext;
          end else if (flush) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= IDLE;
              bus_req   <= 1'b0;
              bus_we    <= 1'b0;
            end else begin
              state_reg <= DRAIN;
              cnt_reg   <= cnt_reg + 16'd1;
            end
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= DONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            resp_valid <= 1'b1;
            exc_code   <= EXC_TMO;
            rdata      <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        DONE: begin
          resp_valid <= 1'b0;
          state_reg  <= IDLE;
        end

        DRAIN: begin
          // The counter keeps running from its WAIT value so a flushed access
          // cannot hang the sequencer longer than a normal one.
          if (bus_ack || (cnt_reg == CNT_LAST)) begin
            state_reg <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [1:0]  exc_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .exc_code(exc_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 0; req_we = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    flush = 0; bus_ack = 0; bus_rdata = 0;
    #2;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    n_cmp++; if (exc_code !== 2'b00) begin n_bad++; $display("FAIL rst_exc got=%0h exp=0", exc_code); end
    n_cmp++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin n_bad++; $display("FAIL rst_bus_outs got we=%0h be=%h addr=%h wd=%h exp=0", bus_we, bus_be, bus_addr, bus_wdata); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    tick();
    reset = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_signed_byte_load();
    drive_req(1'b0, 3'd2, 32'h1003, 32'h0);
    bus_rdata = 32'h80AA55CC;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_c0_stall got=%0h exp=1", stall); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL lb_c0_bus_req got=%0h exp=0", bus_req); end
    tick();
    bus_ack = 1'b1;
    #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL lb_c1_bus_req got=%0h exp=1", bus_req); end
    n_cmp++; if (bus_addr !== 32'h1000) begin n_bad++; $display("FAIL lb_bus_addr got=%h exp=00001000", bus_addr); end
    n_cmp++; if (bus_be !== 4'b1111) begin n_bad++; $display("FAIL lb_bus_be got=%b exp=1111", bus_be); end
    n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL lb_bus_we got=%0h exp=0", bus_we); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_c1_stall got=%0h exp=1", stall); end
    tick();
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL lb_c2_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    n_cmp++; if (exc_code !== 2'b00) begin n_bad++; $display("FAIL lb_exc got=%0h exp=0", exc_code); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lb_c2_stall got=%0h exp=0", stall); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL lb_c2_bus_req got=%0h exp=0", bus_req); end
    req_valid = 1'b0;
    tick();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL lb_c3_resp got=%0h exp=0", resp_valid); end
    n_cmp++; if (rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_rdata_hold got=%h exp=ffffff80", rdata); end
    $display("signed_byte_load: addr=00001003 rdata=%h", rdata);
  endtask

  task automatic test_load_ext();
    logic [2:0]  t_op  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0, 3'd7, 3'd1};
    logic [31:0] t_adr [8] = '{32'h1001, 32'h1000, 32'h1002, 32'h1002, 32'h1000, 32'h1004, 32'h1008, 32'h1003};
    logic [31:0] t_rd  [8] = '{32'h80AA55CC, 32'h80AA55CC, 32'h80AA55CC, 32'h80AA55CC,
                               32'h80AA55CC, 32'h80AA55CC, 32'h12345678, 32'hF0000000};
    logic [31:0] t_exp [8] = '{32'h00000055, 32'hFFFFFFCC, 32'h000080AA, 32'hFFFF80AA,
                               32'h000055CC, 32'h80AA55CC, 32'h12345678, 32'h000000F0};
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, t_op[i], t_adr[i], 32'h0);
      bus_rdata = t_rd[i];
      tick();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      #1;
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL ext%0d_resp got=%0h exp=1", i, resp_valid); end
      n_cmp++; if (rdata !== t_exp[i]) begin n_bad++; $display("FAIL ext%0d_rdata got=%h exp=%h", i, rdata, t_exp[i]); end
      $display("load_ext: op=%0d addr=%h rdata=%h", t_op[i], t_adr[i], rdata);
      req_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_misaligned();
    logic        t_we  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  t_op  [5] = '{3'd0, 3'd3, 3'd4, 3'd0, 3'd5};
    logic [31:0] t_adr [5] = '{32'h3001, 32'h3003, 32'h3001, 32'h3002, 32'h300A};
    logic [1:0]  t_exc [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      drive_req(t_we[i], t_op[i], t_adr[i], 32'h1234);
      tick();
      #1;
      n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL mis%0d_bus_req got=%0h exp=0", i, bus_req); end
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL mis%0d_resp got=%0h exp=1", i, resp_valid); end
      n_cmp++; if (exc_code !== t_exc[i]) begin n_bad++; $display("FAIL mis%0d_exc got=%0h exp=%0h", i, exc_code, t_exc[i]); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mis%0d_rdata got=%h exp=0", i, rdata); end
      $display("misaligned: we=%0d op=%0d addr=%h exc=%0h", t_we[i], t_op[i], t_adr[i], exc_code);
      req_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_half_store();
    drive_req(1'b1, 3'd3, 32'h2002, 32'h0000BEEF);
    bus_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) bus_ack = 1'b1;
      #1;
      n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL sh_c%0d_bus_req got=%0h exp=1", c, bus_req); end
      n_cmp++; if (bus_be !== 4'b1100) begin n_bad++; $display("FAIL sh_c%0d_be got=%b exp=1100", c, bus_be); end
      n_cmp++; if (bus_wdata !== 32'hBEEFBEEF) begin n_bad++; $display("FAIL sh_c%0d_wdata got=%h exp=beefbeef", c, bus_wdata); end
      n_cmp++; if (bus_we !== 1'b1) begin n_bad++; $display("FAIL sh_c%0d_we got=%0h exp=1", c, bus_we); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sh_c%0d_stall got=%0h exp=1", c, stall); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL sh_c%0d_resp got=%0h exp=0", c, resp_valid); end
    end
    tick();
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL sh_c5_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL sh_rdata got=%h exp=0", rdata); end
    n_cmp++; if (exc_code !== 2'b00) begin n_bad++; $display("FAIL sh_exc got=%0h exp=0", exc_code); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sh_c5_stall got=%0h exp=0", stall); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL sh_c5_bus_req got=%0h exp=0", bus_req); end
    $display("half_store: addr=00002002 be=1100 resp_valid=%0d", resp_valid);
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_store_lanes();
    logic [2:0]  t_op  [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd6};
    logic [31:0] t_adr [5] = '{32'h2001, 32'h2003, 32'h2000, 32'h2004, 32'h2008};
    logic [31:0] t_wd  [5] = '{32'h12345678, 32'h000000A5, 32'hCAFEBEEF, 32'hDEADBEEF, 32'h01020304};
    logic [3:0]  t_be  [5] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1111};
    logic [31:0] t_ewd [5] = '{32'h78787878, 32'hA5A5A5A5, 32'hBEEFBEEF, 32'hDEADBEEF, 32'h01020304};
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, t_op[i], t_adr[i], t_wd[i]);
      tick();
      bus_ack = 1'b1;
      #1;
      n_cmp++; if (bus_be !== t_be[i]) begin n_bad++; $display("FAIL st%0d_be got=%b exp=%b", i, bus_be, t_be[i]); end
      n_cmp++; if (bus_wdata !== t_ewd[i]) begin n_bad++; $display("FAIL st%0d_wdata got=%h exp=%h", i, bus_wdata, t_ewd[i]); end
      n_cmp++; if (bus_addr !== {t_adr[i][31:2], 2'b00}) begin n_bad++; $display("FAIL st%0d_addr got=%h exp=%h", i, bus_addr, {t_adr[i][31:2], 2'b00}); end
      tick();
      bus_ack = 1'b0;
      #1;
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL st%0d_resp got=%0h exp=1", i, resp_valid); end
      $display("store_lane: op=%0d addr=%h be=%b wdata=%h", t_op[i], t_adr[i], t_be[i], t_ewd[i]);
      req_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_timeout();
    drive_req(1'b0, 3'd0, 32'h4000, 32'h0);
    bus_rdata = 32'h55555555;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL to_c%0d_bus_req got=%0h exp=1", c, bus_req); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL to_c%0d_resp got=%0h exp=0", c, resp_valid); end
    end
    tick();
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL to_c5_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (exc_code !== 2'b11) begin n_bad++; $display("FAIL to_exc got=%0h exp=3", exc_code); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL to_c5_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata got=%h exp=0", rdata); end
    req_valid = 1'b0;
    tick();            // cycle 6
    tick();            // cycle 7: late ack while idle
    bus_ack = 1'b1;
    tick();            // cycle 8
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL to_late_ack_resp got=%0h exp=0", resp_valid); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL to_late_ack_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if (exc_code !== 2'b11) begin n_bad++; $display("FAIL to_exc_hold got=%0h exp=3", exc_code); end
    $display("timeout: exc=%0h after 4 bus_req cycles", exc_code);
    tick();
  endtask

  task automatic test_flush_wait();
    drive_req(1'b0, 3'd0, 32'h5000, 32'h0);
    bus_rdata = 32'h99999999;
    tick();            // cycle 1
    tick();            // cycle 2: flush
    flush = 1'b1;
    req_valid = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_c2_stall got=%0h exp=0", stall); end
    tick();            // cycle 3
    flush = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_c3_stall got=%0h exp=1", stall); end
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fl_c3_bus_req got=%0h exp=1", bus_req); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_c3_resp got=%0h exp=0", resp_valid); end
    tick();            // cycle 4: ack
    bus_ack = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_c4_stall got=%0h exp=1", stall); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_c4_resp got=%0h exp=0", resp_valid); end
    tick();            // cycle 5
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_c5_resp got=%0h exp=0", resp_valid); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL fl_c5_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_c5_stall got=%0h exp=0", stall); end
    drive_req(1'b0, 3'd0, 32'h5004, 32'h0);
    bus_rdata = 32'h44444444;
    tick();            // cycle 6
    bus_ack = 1'b1;
    #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fl_new_bus_req got=%0h exp=1", bus_req); end
    n_cmp++; if (bus_addr !== 32'h5004) begin n_bad++; $display("FAIL fl_new_addr got=%h exp=00005004", bus_addr); end
    tick();            // cycle 7
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL fl_new_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (rdata !== 32'h44444444) begin n_bad++; $display("FAIL fl_new_rdata got=%h exp=44444444", rdata); end
    $display("flush_wait: drained, next load rdata=%h", rdata);
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_ack();
    drive_req(1'b0, 3'd0, 32'h8000, 32'h0);
    bus_rdata = 32'h33333333;
    tick();            // cycle 1: ack and flush together
    bus_ack = 1'b1;
    flush = 1'b1;
    req_valid = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fa_c1_bus_req got=%0h exp=1", bus_req); end
    tick();            // cycle 2
    bus_ack = 1'b0;
    flush = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fa_c2_resp got=%0h exp=0", resp_valid); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL fa_c2_bus_req got=%0h exp=0", bus_req); end
    tick();            // cycle 3
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fa_c3_resp got=%0h exp=0", resp_valid); end
    $display("flush_ack: response suppressed resp_valid=%0d", resp_valid);
  endtask

  task automatic test_back_to_back();
    // Ack stays high throughout; the ack seen in DONE and IDLE must be ignored.
    drive_req(1'b0, 3'd0, 32'h7000, 32'h0);
    bus_rdata = 32'h11111111;
    tick();            // cycle 1
    bus_ack = 1'b1;
    #1;
    n_cmp++; if (bus_addr !== 32'h7000) begin n_bad++; $display("FAIL b2b_a_addr got=%h exp=00007000", bus_addr); end
    tick();            // cycle 2
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_a_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (rdata !== 32'h11111111) begin n_bad++; $display("FAIL b2b_a_rdata got=%h exp=11111111", rdata); end
    tick();            // cycle 3: idle, new request
    drive_req(1'b0, 3'd0, 32'h7004, 32'h0);
    bus_rdata = 32'h22222222;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_c3_resp got=%0h exp=0", resp_valid); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_c3_stall got=%0h exp=1", stall); end
    tick();            // cycle 4
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL b2b_b_bus_req got=%0h exp=1", bus_req); end
    n_cmp++; if (bus_addr !== 32'h7004) begin n_bad++; $display("FAIL b2b_b_addr got=%h exp=00007004", bus_addr); end
    tick();            // cycle 5
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_b_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (rdata !== 32'h22222222) begin n_bad++; $display("FAIL b2b_b_rdata got=%h exp=22222222", rdata); end
    $display("back_to_back: responses at cycles 2 and 5 rdata=%h", rdata);
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    drive_req(1'b0, 3'd0, 32'h6000, 32'h0);
    bus_rdata = 32'hABCDEF01;
    tick();            // cycle 1: WAIT
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL ar_c1_bus_req got=%0h exp=1", bus_req); end
    req_valid = 1'b0;
    #1;
    reset = 1'b0;      // between clock edges
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL ar_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_stall got=%0h exp=0", stall); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL ar_resp got=%0h exp=0", resp_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL ar_rdata got=%h exp=0", rdata); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL ar_after_bus_req got=%0h exp=0", bus_req); end
    drive_req(1'b0, 3'd4, 32'h6006, 32'h0);
    bus_rdata = 32'h5A5A8001;
    tick();
    bus_ack = 1'b1;
    #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL ar_new_bus_req got=%0h exp=1", bus_req); end
    tick();
    bus_ack = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL ar_new_resp got=%0h exp=1", resp_valid); end
    n_cmp++; if (rdata !== 32'h00005A5A) begin n_bad++; $display("FAIL ar_new_rdata got=%h exp=00005a5a", rdata); end
    $display("async_reset: recovered, lh rdata=%h", rdata);
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_signed_byte_load();
    test_load_ext();
    test_misaligned();
    test_half_store();
    test_store_lanes();
    test_timeout();
    test_flush_wait();
    test_flush_ack();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
